// File: rtl/hs_unit_skid_buffer.sv
// Two-entry valid/ready register slice (skid buffer).
// Every output (s_ready, m_valid, m_data) comes from a flop, which breaks
// all combinational paths between source and sink at full throughput.
// The skid register catches the beat in flight when the sink stalls.
// Optional feature macro: HS_SKID_BUFFER_FLUSH_EN adds a synchronous
// active-high 'flush' input that empties the buffer.
module hs_unit_skid_buffer #(
    parameter type DATA_TYPE = logic
) (
`ifdef HS_SKID_BUFFER_FLUSH_EN
    input  logic     flush,
`endif
    input  logic     clk,
    input  logic     rst_n,
    input  logic     s_valid,
    output logic     s_ready,
    input  DATA_TYPE s_data,
    output logic     m_valid,
    input  logic     m_ready,
    output DATA_TYPE m_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e   state_q, state_d;
    DATA_TYPE main_q, main_d;
    DATA_TYPE skid_q;

    logic main_load;
    logic main_from_skid;
    logic skid_load;
    logic in_xfer;
    logic out_xfer;
    logic flush_req;

`ifdef HS_SKID_BUFFER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Output decode from registered state only; the unused encoding looks idle.
    always_comb begin
        m_valid = 1'b0;
        s_ready = 1'b1;
        case (state_q)
            EMPTY: begin
                m_valid = 1'b0;
                s_ready = 1'b1;
            end
            BUSY: begin
                m_valid = 1'b1;
                s_ready = 1'b1;
            end
            FULL: begin
                m_valid = 1'b1;
                s_ready = 1'b0;
            end
            default: begin
                m_valid = 1'b0;
                s_ready = 1'b1;
            end
        endcase
    end

    assign in_xfer  = s_valid && s_ready;
    assign out_xfer = m_valid && m_ready;
    assign m_data   = main_q;

    // Next-state and datapath-enable logic; flush overrides any handshake.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    skid_load = 1'b1;
                    state_d   = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush_req) begin
            state_d        = EMPTY;
            main_load      = 1'b0;
            main_from_skid = 1'b0;
            skid_load      = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : s_data;

    // Control state register: the only state that is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers carry no reset; validity is tracked by state_q.
    always_ff @(posedge clk) begin
        if (main_load) begin
            main_q <= main_d;
        end
        if (skid_load) begin
            skid_q <= s_data;
        end
    end

endmodule

// File: tb/tb_hs_unit_skid_buffer.sv
// Directed + random bench for hs_unit_skid_buffer with a queue scoreboard.
module tb_hs_unit_skid_buffer;

    typedef logic [15:0] data_t;

    logic  clk;
    logic  rst_n;
    logic  s_valid;
    logic  s_ready;
    data_t s_data;
    logic  m_valid;
    logic  m_ready;
    data_t m_data;
`ifdef HS_SKID_BUFFER_FLUSH_EN
    logic  flush;
`endif

    int    checks;
    int    failures;
    int    n_out;
    data_t sb_q[$];
    logic  hold_prev;
    data_t hold_data;

    hs_unit_skid_buffer #(.DATA_TYPE(data_t)) dut (
`ifdef HS_SKID_BUFFER_FLUSH_EN
        .flush   (flush),
`endif
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs at each falling edge: compares outputs against the occupancy model
    // and records the handshakes that will happen at the next rising edge.
    task automatic monitor();
        data_t exp_d;
        if (!rst_n) begin
            sb_q.delete();
            hold_prev = 1'b0;
            return;
        end
        check("m_valid_vs_model", {31'd0, m_valid}, {31'd0, sb_q.size() != 0});
        check("s_ready_vs_model", {31'd0, s_ready}, {31'd0, sb_q.size() < 2});
        if (hold_prev) check("m_data_stable", {16'd0, m_data}, {16'd0, hold_data});
`ifdef HS_SKID_BUFFER_FLUSH_EN
        if (flush) begin
            sb_q.delete();
            hold_prev = 1'b0;
            return;
        end
`endif
        if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                check("spurious_out", {31'd0, m_valid}, 32'd0);
            end else begin
                exp_d = sb_q.pop_front();
                check("sb_data", {16'd0, m_data}, {16'd0, exp_d});
                n_out++;
            end
        end
        if (s_valid && s_ready) sb_q.push_back(s_data);
        hold_prev = m_valid && !m_ready;
        hold_data = m_data;
    endtask

    initial begin
        int   sent;
        int   cyc;
        int   base_out;
        logic acc;

        checks    = 0;
        failures  = 0;
        n_out     = 0;
        hold_prev = 1'b0;
        hold_data = '0;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
`ifdef HS_SKID_BUFFER_FLUSH_EN
        flush     = 1'b0;
`endif

        fork
            forever begin
                @(negedge clk);
                monitor();
            end
        join_none

        // Reset release with idle source
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_m_valid", {31'd0, m_valid}, 32'd0);
            check("reset_s_ready", {31'd0, s_ready}, 32'd1);
        end

        // Streaming at one beat per cycle
        step();
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = data_t'(i);
            step();
            check("stream_m_data", {16'd0, m_data}, i);
            check("stream_s_ready", {31'd0, s_ready}, 32'd1);
        end
        s_valid = 1'b0;
        step();
        check("stream_drained", {31'd0, m_valid}, 32'd0);

        // Backpressure: two beats fill the buffer, third is held by the source
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h00A1;
        step();
        check("bp_after_a1_s_ready", {31'd0, s_ready}, 32'd1);
        s_data = 16'h00A2;
        step();
        check("bp_full_s_ready", {31'd0, s_ready}, 32'd0);
        s_data = 16'h00A3;
        step();
        check("bp_hold_s_ready", {31'd0, s_ready}, 32'd0);
        check("bp_hold_m_data", {16'd0, m_data}, 32'h00A1);
        m_ready = 1'b1;
        step();
        check("bp_a1_left_s_ready", {31'd0, s_ready}, 32'd1);
        check("bp_second_m_data", {16'd0, m_data}, 32'h00A2);
        step();
        check("bp_third_m_data", {16'd0, m_data}, 32'h00A3);
        s_valid = 1'b0;
        step();
        check("bp_drained", {31'd0, m_valid}, 32'd0);

        // Random valid/ready, 1000 counter beats
        sent     = 0;
        cyc      = 0;
        base_out = n_out;
        s_valid  = 1'b0;
        while ((n_out - base_out) < 1000 && cyc < 20000) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) sent++;
            if (!s_valid || acc) begin
                s_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
                s_data  = data_t'(sent);
            end
            m_ready = ($urandom_range(0, 1) == 1);
        end
        check("random_beats_out", n_out - base_out, 32'd1000);
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) step();
        check("random_drained", {31'd0, m_valid}, 32'd0);

        // Async reset while FULL with B1, B2 buffered
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h00B1;
        step();
        s_data = 16'h00B2;
        step();
        s_valid = 1'b0;
        check("rst_pre_full", {31'd0, s_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("async_rst_s_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_no_stale", {31'd0, m_valid}, 32'd0);
        end

`ifdef HS_SKID_BUFFER_FLUSH_EN
        // Flush while FULL with a concurrent offered beat
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h00C1;
        step();
        s_data = 16'h00C2;
        step();
        s_data = 16'h00C3;
        flush  = 1'b1;
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        check("flush_m_valid", {31'd0, m_valid}, 32'd0);
        check("flush_s_ready", {31'd0, s_ready}, 32'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_flush_idle", {31'd0, m_valid}, 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
